// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer:
// state codes, lamp patterns, default dwell times and duration helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5,
    FLASH_ON  = 3'd6,
    FLASH_OFF = 3'd7
  } state_e;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_e;

  // {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int DEF_GREEN_TIME     = 20;
  localparam int DEF_YELLOW_TIME    = 3;
  localparam int DEF_ALLRED_TIME    = 2;
  localparam int DEF_WALK_TIME      = 10;
  localparam int DEF_FLASH_ON_TIME  = 5;
  localparam int DEF_FLASH_OFF_TIME = 4;

  typedef struct packed {
    logic [5:0] green;
    logic [5:0] yellow;
    logic [5:0] allred;
    logic [5:0] walk;
    logic [5:0] flash_on;
    logic [5:0] flash_off;
  } durations_t;

  function automatic logic [5:0] phase_duration(
    input state_e     s,
    input durations_t d
  );
    phase_duration = d.allred;
    unique case (s)
      ALL_RED:   phase_duration = d.allred;
      NS_GREEN,
      EW_GREEN:  phase_duration = d.green;
      NS_YELLOW,
      EW_YELLOW: phase_duration = d.yellow;
      PED_WALK:  phase_duration = d.walk;
      FLASH_ON:  phase_duration = d.flash_on;
      FLASH_OFF: phase_duration = d.flash_off;
    endcase
  endfunction

  // The counter only reloads on a change of timer_value, so any two
  // equal durations would leave it stuck at zero across a transition.
  function automatic bit times_ok(
    input int g,
    input int y,
    input int a,
    input int w,
    input int fon,
    input int foff
  );
    int t [6];
    t = '{g, y, a, w, fon, foff};
    times_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i] < 1 || t[i] > 63) times_ok = 1'b0;
      for (int j = i + 1; j < 6; j++) begin
        if (t[i] == t[j]) times_ok = 1'b0;
      end
    end
  endfunction

endpackage

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection phase sequencer with pedestrian and night flash.
// In: clk, rst_n (async, active-high), counter_value, ped_req, night_mode.
// Out: timer_value, ns_light, ew_light, ped_walk, phase (all registered).
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_TIME     = DEF_GREEN_TIME,
  parameter int YELLOW_TIME    = DEF_YELLOW_TIME,
  parameter int ALLRED_TIME    = DEF_ALLRED_TIME,
  parameter int WALK_TIME      = DEF_WALK_TIME,
  parameter int FLASH_ON_TIME  = DEF_FLASH_ON_TIME,
  parameter int FLASH_OFF_TIME = DEF_FLASH_OFF_TIME
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] counter_value,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [5:0] timer_value,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam bit TIMES_OK = times_ok(
    GREEN_TIME, YELLOW_TIME, ALLRED_TIME,
    WALK_TIME, FLASH_ON_TIME, FLASH_OFF_TIME
  );

  if (!TIMES_OK) begin : g_bad_times
    $error("traffic_light_ctrl: durations must be distinct, 1..63");
  end

  localparam durations_t DUR = '{
    green:     6'(GREEN_TIME),
    yellow:    6'(YELLOW_TIME),
    allred:    6'(ALLRED_TIME),
    walk:      6'(WALK_TIME),
    flash_on:  6'(FLASH_ON_TIME),
    flash_off: 6'(FLASH_OFF_TIME)
  };

  function automatic state_e green_of(input road_e r);
    return (r == ROAD_NS) ? NS_GREEN : EW_GREEN;
  endfunction

  state_e     state_q, state_d;
  road_e      next_road_q, next_road_d;
  logic       blank_q, blank_d;
  logic       ped_pending_q, ped_pending_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       walk_q, walk_d;
  logic [5:0] timer_q, timer_d;
  logic       phase_end;

  // The counter still holds the old zero until its negedge reload,
  // so the first cycle of every phase ignores counter_value.
  assign phase_end = (counter_value == 6'd0) && !blank_q;

  always_comb begin
    state_d     = state_q;
    next_road_d = next_road_q;
    if (phase_end) begin
      unique case (state_q)
        NS_GREEN:  state_d = NS_YELLOW;
        EW_GREEN:  state_d = EW_YELLOW;
        NS_YELLOW,
        EW_YELLOW: begin
          state_d     = ALL_RED;
          next_road_d = road_e'(~next_road_q);
        end
        ALL_RED: begin
          if (night_mode)         state_d = FLASH_ON;
          else if (ped_pending_q) state_d = PED_WALK;
          else                    state_d = green_of(next_road_q);
        end
        PED_WALK:  state_d = green_of(next_road_q);
        FLASH_ON:  state_d = FLASH_OFF;
        FLASH_OFF: state_d = night_mode ? FLASH_ON : ALL_RED;
      endcase
    end

    blank_d = (state_d != state_q);

    // Entry into the walk phase consumes the request, even one
    // arriving in that same cycle.
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_pending_q | ped_req;
    end

    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    unique case (state_d)
      NS_GREEN:  ns_d = LAMP_GRN;
      NS_YELLOW: ns_d = LAMP_YEL;
      EW_GREEN:  ew_d = LAMP_GRN;
      EW_YELLOW: ew_d = LAMP_YEL;
      PED_WALK:  walk_d = 1'b1;
      FLASH_ON: begin
        ns_d = LAMP_YEL;
        ew_d = LAMP_YEL;
      end
      FLASH_OFF: begin
        ns_d = LAMP_OFF;
        ew_d = LAMP_OFF;
      end
      ALL_RED: ;
    endcase

    timer_d = phase_duration(state_d, DUR);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= ALL_RED;
      next_road_q   <= ROAD_NS;
      blank_q       <= 1'b1;
      ped_pending_q <= 1'b0;
      ns_q          <= LAMP_RED;
      ew_q          <= LAMP_RED;
      walk_q        <= 1'b0;
      timer_q       <= DUR.allred;
    end else begin
      state_q       <= state_d;
      next_road_q   <= next_road_d;
      blank_q       <= blank_d;
      ped_pending_q <= ped_pending_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
      timer_q       <= timer_d;
    end
  end

  assign timer_value = timer_q;
  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign ped_walk    = walk_q;
  assign phase       = state_q;

endmodule
